stack_unit: RTL and testbench

- Hardware LIFO stack; sits directly downstream of the control signal module.
- Consumes its StackPush/StackPop strobes, qualified by the pipeline's push/pop enable.
- Holds WIDTH-bit register values for PUSH (opcode 10010) and POP (opcode 10011).
- Returns popped data to the register-file write-back mux one cycle later, and flags overflow and underflow for the exception logic.

---
 rtl/stack_unit.sv | 112 +++++++++++
 tb/tb_stack_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - hardware LIFO stack with registered pop data and sticky overflow/underflow flags
// Push/pop strobes are qualified by stall; flush clears the pointer; storage is not reset.
module stack_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StackPush,
  input  logic             StackPop,
  input  logic             stall,
  input  logic             flush,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top_data,
  output logic [AW:0]      sp,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic          psh;
  logic          pp;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic          ovf_set;
  logic          unf_set;
  logic [WIDTH-1:0] top_entry;

  assign psh   = StackPush & ~stall;
  assign pp    = StackPop & ~stall;
  assign empty = (sp == '0);
  assign full  = (sp == FULL_CNT);

  // Low AW bits of sp minus one wraps to DEPTH-1 when full, which is the top slot.
  assign top_idx   = sp[AW-1:0] - 1'b1;
  assign top_entry = mem[top_idx];
  assign top_data  = empty ? '0 : top_entry;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = sp[AW-1:0];
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!flush) begin
      if (psh && !pp) begin
        wr_en   = ~full;
        ovf_set = full;
      end else if (!psh && pp) begin
        unf_set = empty;
      end else if (psh && pp) begin
        // Simultaneous push/pop replaces the top entry in place.
        wr_en  = ~empty;
        wr_idx = top_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp        <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
      pop_valid <= 1'b0;
      if (flush) begin
        sp <= '0;
      end else begin
        case ({psh, pp})
          2'b10: begin
            if (!full) begin
              sp <= sp + ONE;
            end
          end
          2'b01: begin
            if (!empty) begin
              pop_data  <= top_entry;
              sp        <= sp - ONE;
              pop_valid <= 1'b1;
            end
          end
          2'b11: begin
            pop_data  <= empty ? push_data : top_entry;
            pop_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - directed table-driven bench for stack_unit
// Vectors carry inputs plus hand-computed expected outputs after the sampling edge.
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        StackPush, StackPop, stall, flush, err_clr;
  logic [31:0] push_data;
  logic [31:0] pop_data;
  logic        pop_valid;
  logic [31:0] top_data;
  logic [4:0]  sp;
  logic        empty, full, overflow, underflow;

  int total = 0;
  int bad   = 0;

  stack_unit #(.WIDTH(32), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .StackPush(StackPush), .StackPop(StackPop),
    .stall(stall), .flush(flush), .err_clr(err_clr), .push_data(push_data),
    .pop_data(pop_data), .pop_valid(pop_valid), .top_data(top_data), .sp(sp),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        psh, pp, stl, fl, ec;
    logic [31:0] d;
    logic        pv;
    logic [31:0] pd;
    logic [4:0]  sp;
    logic        ovf, unf;
    logic [31:0] top;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic psh, logic pp, logic stl, logic fl, logic ec,
                              logic [31:0] d, logic pv, logic [31:0] pd, logic [4:0] s,
                              logic ovf, logic unf, logic [31:0] top);
    vec_t v;
    v.psh = psh; v.pp = pp; v.stl = stl; v.fl = fl; v.ec = ec; v.d = d;
    v.pv = pv; v.pd = pd; v.sp = s; v.ovf = ovf; v.unf = unf; v.top = top;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic psh, input logic pp, input logic stl, input logic fl,
                      input logic ec, input logic [31:0] d);
    @(negedge clk);
    StackPush = psh; StackPop = pp; stall = stl; flush = fl; err_clr = ec; push_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic pv, input logic [31:0] pd,
                           input logic [4:0] s, input logic ovf, input logic unf,
                           input logic [31:0] top);
    chk({tag, ".pop_valid"}, 32'(pop_valid), 32'(pv));
    chk({tag, ".pop_data"}, pop_data, pd);
    chk({tag, ".sp"}, 32'(sp), 32'(s));
    chk({tag, ".empty"}, 32'(empty), 32'(s == 5'd0));
    chk({tag, ".full"}, 32'(full), 32'(s == 5'd16));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(unf));
    chk({tag, ".top_data"}, top_data, top);
  endtask

  initial begin
    reset = 1'b0;
    StackPush = 0; StackPop = 0; stall = 0; flush = 0; err_clr = 0; push_data = '0;

    // LIFO order, empty-pop errors, err_clr, simultaneous push/pop, stall and flush
    vecs.push_back(mk(1,0,0,0,0, 32'h11, 0, 32'h0,  5'd1, 0,0, 32'h11));
    vecs.push_back(mk(1,0,0,0,0, 32'h22, 0, 32'h0,  5'd2, 0,0, 32'h22));
    vecs.push_back(mk(1,0,0,0,0, 32'h33, 0, 32'h0,  5'd3, 0,0, 32'h33));
    vecs.push_back(mk(0,1,0,0,0, 32'h0,  1, 32'h33, 5'd2, 0,0, 32'h22));
    vecs.push_back(mk(0,1,0,0,0, 32'h0,  1, 32'h22, 5'd1, 0,0, 32'h11));
    vecs.push_back(mk(0,1,0,0,0, 32'h0,  1, 32'h11, 5'd0, 0,0, 32'h0));
    vecs.push_back(mk(0,1,0,0,0, 32'h0,  0, 32'h11, 5'd0, 0,1, 32'h0));
    vecs.push_back(mk(0,0,0,0,1, 32'h0,  0, 32'h11, 5'd0, 0,0, 32'h0));
    vecs.push_back(mk(0,1,0,0,1, 32'h0,  0, 32'h11, 5'd0, 0,1, 32'h0));
    vecs.push_back(mk(0,0,0,0,1, 32'h0,  0, 32'h11, 5'd0, 0,0, 32'h0));
    vecs.push_back(mk(1,0,0,0,0, 32'hAA, 0, 32'h11, 5'd1, 0,0, 32'hAA));
    vecs.push_back(mk(1,1,0,0,0, 32'hBB, 1, 32'hAA, 5'd1, 0,0, 32'hBB));
    vecs.push_back(mk(0,1,0,0,0, 32'h0,  1, 32'hBB, 5'd0, 0,0, 32'h0));
    vecs.push_back(mk(1,1,0,0,0, 32'h5,  1, 32'h5,  5'd0, 0,0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,  0, 32'h5,  5'd0, 0,0, 32'h0));
    vecs.push_back(mk(1,0,0,0,0, 32'h1,  0, 32'h5,  5'd1, 0,0, 32'h1));
    vecs.push_back(mk(1,0,0,0,0, 32'h2,  0, 32'h5,  5'd2, 0,0, 32'h2));
    vecs.push_back(mk(0,1,1,0,0, 32'h0,  0, 32'h5,  5'd2, 0,0, 32'h2));
    vecs.push_back(mk(1'bx,1'bx,1,0,0, 32'h77, 0, 32'h5, 5'd2, 0,0, 32'h2));
    vecs.push_back(mk(0,1,0,1,0, 32'h0,  0, 32'h5,  5'd0, 0,0, 32'h0));
    vecs.push_back(mk(0,1,0,0,0, 32'h0,  0, 32'h5,  5'd0, 0,1, 32'h0));
    vecs.push_back(mk(0,0,0,0,1, 32'h0,  0, 32'h5,  5'd0, 0,0, 32'h0));

    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 32'h0, 5'd0, 0, 0, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].psh, vecs[i].pp, vecs[i].stl, vecs[i].fl, vecs[i].ec, vecs[i].d);
      chk_state($sformatf("vec%0d", i), vecs[i].pv, vecs[i].pd, vecs[i].sp,
                vecs[i].ovf, vecs[i].unf, vecs[i].top);
    end

    // Fill to capacity, overflow, pop, then push+pop while full
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0, 0, 32'h100 + 32'(i));
    end
    chk_state("fill", 0, 32'h5, 5'd16, 0, 0, 32'h10F);
    step(1, 0, 0, 0, 0, 32'hDEAD);
    chk_state("ovf", 0, 32'h5, 5'd16, 1, 0, 32'h10F);
    step(0, 1, 0, 0, 0, 32'h0);
    chk_state("pop_full", 1, 32'h10F, 5'd15, 1, 0, 32'h10E);
    step(1, 0, 0, 0, 1, 32'h200);
    chk_state("refill", 0, 32'h10F, 5'd16, 0, 0, 32'h200);
    step(1, 1, 0, 0, 0, 32'h300);
    chk_state("swap_full", 1, 32'h200, 5'd16, 0, 0, 32'h300);
    step(0, 0, 0, 1, 0, 32'h0);
    chk_state("flush_full", 0, 32'h200, 5'd0, 0, 0, 32'h0);

    // Async reset between edges discards contents and clears pop_data immediately
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 32'h40 + 32'(i));
    end
    step(0, 1, 0, 0, 0, 32'h0);
    chk_state("pre_rst", 1, 32'h43, 5'd3, 0, 0, 32'h42);
    #2;
    reset = 1'b0;
    #1;
    chk_state("async_rst", 0, 32'h0, 5'd0, 0, 0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 1, 0, 0, 0, 32'h0);
    chk_state("post_rst_pop", 0, 32'h0, 5'd0, 0, 1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
